// File: rtl/mac8_dotp_seq.sv
// mac8_dotp_seq: sequences one packed-byte dot-product job into the mac8 FU and returns the tagged result
module mac8_dotp_seq #(
  parameter int XLEN          = 32,
  parameter int LEN_W         = 8,
  parameter int TRANS_ID_BITS = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [LEN_W-1:0]         cmd_len_i,
  input  logic [TRANS_ID_BITS-1:0] cmd_trans_id_i,
  input  logic                     op_valid_i,
  output logic                     op_ready_o,
  input  logic [XLEN-1:0]          op_a_i,
  input  logic [XLEN-1:0]          op_b_i,
  output logic                     mac_valid_o,
  output logic                     mac_init_o,
  output logic [XLEN-1:0]          mac_op_a_o,
  output logic [XLEN-1:0]          mac_op_b_o,
  input  logic [XLEN-1:0]          mac_result_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [XLEN-1:0]          res_data_o,
  output logic [TRANS_ID_BITS-1:0] res_trans_id_o,
  output logic                     busy_o
);
  typedef enum logic [1:0] {IDLE, STREAM, RESP} state_t;
  state_t                   state_q, state_d;
  logic [LEN_W-1:0]         cnt_q, cnt_d;
  logic                     first_q, first_d;
  logic [XLEN-1:0]          res_data_q, res_data_d;
  logic [TRANS_ID_BITS-1:0] tid_q, tid_d;
  logic                     beat, cmd_hs;
  assign cmd_ready_o    = (state_q == IDLE) & ~flush_i;
  assign op_ready_o     = state_q == STREAM;
  assign beat           = op_ready_o & op_valid_i & ~flush_i;
  assign cmd_hs         = cmd_valid_i & cmd_ready_o;
  assign mac_valid_o    = beat;
  assign mac_init_o     = first_q;
  assign mac_op_a_o     = op_a_i;
  assign mac_op_b_o     = op_b_i;
  assign res_valid_o    = state_q == RESP;
  assign res_data_o     = res_data_q;
  assign res_trans_id_o = tid_q;
  assign busy_o         = state_q != IDLE;
  // flush outranks everything, so a last beat coinciding with flush is dropped
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    first_d    = first_q;
    res_data_d = res_data_q;
    tid_d      = tid_q;
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      first_d = 1'b0;
    end else if (cmd_hs) begin
      tid_d      = cmd_trans_id_i;
      cnt_d      = cmd_len_i;
      first_d    = 1'b1;
      state_d    = (cmd_len_i == '0) ? RESP : STREAM;
      res_data_d = (cmd_len_i == '0) ? '0 : res_data_q;
    end else if (beat) begin
      res_data_d = mac_result_i;
      first_d    = 1'b0;
      cnt_d      = cnt_q - LEN_W'(1);
      state_d    = (cnt_q == LEN_W'(1)) ? RESP : STREAM;
    end else if (res_valid_o & res_ready_i) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      first_q    <= 1'b0;
      res_data_q <= '0;
      tid_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      first_q    <= first_d;
      res_data_q <= res_data_d;
      tid_q      <= tid_d;
    end
  end
endmodule
